prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 25 ++
 rtl/prog_loader.sv | 130 +++++++++++++
 tb/tb_prog_loader.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Board-side bus of the program loader: switch/key inputs plus the
// program-memory write port and status outputs.
interface prog_loader_if;
  logic [7:0]  SW;
  logic        key_load;
  logic        key_enter;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic        cpu_hold;
  logic [7:0]  word_count;
  logic        full;
  logic        done;
  logic [2:0]  state_dbg;

  modport master (
    input  SW, key_load, key_enter,
    output prog_we, prog_addr, prog_data, cpu_hold, word_count, full, done, state_dbg
  );

  modport slave (
    output SW, key_load, key_enter,
    input  prog_we, prog_addr, prog_data, cpu_hold, word_count, full, done, state_dbg
  );
endinterface

// File: rtl/prog_loader.sv
// Loads 16-bit program words from switches into program memory, two bytes
// per word entered with pushbuttons, holding the CPU in reset meanwhile.
module prog_loader #(
  parameter logic [7:0] LAST_ADDR = 8'd255
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  logic [1:0]  load_sync_q, enter_sync_q;
  logic        load_prev_q, enter_prev_q;
  logic        load_p_q, enter_p_q;

  state_e      state_q;
  logic [7:0]  hi_byte_q;
  logic        prog_we_q;
  logic [7:0]  prog_addr_q;
  logic [15:0] prog_data_q;
  logic        cpu_hold_q;
  logic [7:0]  word_count_q;
  logic        full_q;
  logic        done_q;

  // Keys are active-low: reset to 1 so a released key never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_sync_q  <= 2'b11;
      enter_sync_q <= 2'b11;
      load_prev_q  <= 1'b1;
      enter_prev_q <= 1'b1;
      load_p_q     <= 1'b0;
      enter_p_q    <= 1'b0;
    end else begin
      load_sync_q  <= {load_sync_q[0], bus.key_load};
      enter_sync_q <= {enter_sync_q[0], bus.key_enter};
      load_prev_q  <= load_sync_q[1];
      enter_prev_q <= enter_sync_q[1];
      load_p_q     <= load_prev_q & ~load_sync_q[1];
      enter_p_q    <= enter_prev_q & ~enter_sync_q[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hi_byte_q    <= 8'd0;
      prog_we_q    <= 1'b0;
      prog_addr_q  <= 8'd0;
      prog_data_q  <= 16'd0;
      cpu_hold_q   <= 1'b0;
      word_count_q <= 8'd0;
      full_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      prog_we_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_p_q) begin
            prog_addr_q  <= 8'd0;
            word_count_q <= 8'd0;
            full_q       <= 1'b0;
            cpu_hold_q   <= 1'b1;
            state_q      <= HI;
          end
        end
        HI: begin
          if (load_p_q) begin
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else if (enter_p_q) begin
            hi_byte_q <= bus.SW;
            state_q   <= LO;
          end
        end
        LO: begin
          // A load here abandons the half-entered word.
          if (load_p_q) begin
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else if (enter_p_q) begin
            prog_data_q <= {hi_byte_q, bus.SW};
            prog_we_q   <= 1'b1;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          if (word_count_q != 8'hFF) word_count_q <= word_count_q + 8'd1;
          if (prog_addr_q == LAST_ADDR) begin
            full_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            prog_addr_q <= prog_addr_q + 8'd1;
            state_q     <= HI;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          cpu_hold_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.prog_we    = prog_we_q;
  assign bus.prog_addr  = prog_addr_q;
  assign bus.prog_data  = prog_data_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.word_count = word_count_q;
  assign bus.full       = full_q;
  assign bus.done       = done_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (full-size and LAST_ADDR=1), with a
// write-strobe scoreboard per instance.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_loader_if bus ();
  prog_loader_if bus2 ();

  prog_loader #(.LAST_ADDR(8'd255)) dut  (.clk(clk), .rst(rst), .bus(bus.master));
  prog_loader #(.LAST_ADDR(8'd1))   dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  int total = 0;
  int bad = 0;
  int strobes = 0, strobes2 = 0, dones = 0, dones2 = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp2_q[$];
  logic [23:0] e1, e2;

  // Every write strobe is checked against the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (bus.prog_we === 1'b1) begin
      strobes++; total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL strobe unexpected got addr=%h data=%h want none", bus.prog_addr, bus.prog_data);
      end else begin
        e1 = exp_q.pop_front();
        if ({bus.prog_addr, bus.prog_data} !== e1) begin
          bad++; $display("FAIL strobe got=%h want=%h", {bus.prog_addr, bus.prog_data}, e1);
        end
      end
    end
    if (bus2.prog_we === 1'b1) begin
      strobes2++; total++;
      if (exp2_q.size() == 0) begin
        bad++; $display("FAIL strobe2 unexpected got addr=%h data=%h want none", bus2.prog_addr, bus2.prog_data);
      end else begin
        e2 = exp2_q.pop_front();
        if ({bus2.prog_addr, bus2.prog_data} !== e2) begin
          bad++; $display("FAIL strobe2 got=%h want=%h", {bus2.prog_addr, bus2.prog_data}, e2);
        end
      end
    end
    if (bus.done === 1'b1) dones++;
    if (bus2.done === 1'b1) dones2++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic press(input bit sel, input bit ld, input bit en, input int hold);
    @(posedge clk); #1;
    if (sel) begin
      if (ld) bus2.key_load = 1'b0;
      if (en) bus2.key_enter = 1'b0;
    end else begin
      if (ld) bus.key_load = 1'b0;
      if (en) bus.key_enter = 1'b0;
    end
    repeat (hold) @(posedge clk);
    #1;
    bus.key_load = 1'b1; bus.key_enter = 1'b1;
    bus2.key_load = 1'b1; bus2.key_enter = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.prog_we, bus.prog_addr, bus.prog_data, bus.cpu_hold, bus.word_count,
         bus.full, bus.done, bus.state_dbg} !== 38'd0) begin
      bad++; $display("FAIL reset.outputs got we=%b addr=%h data=%h hold=%b cnt=%h full=%b done=%b st=%0d want all 0",
        bus.prog_we, bus.prog_addr, bus.prog_data, bus.cpu_hold, bus.word_count, bus.full, bus.done, bus.state_dbg);
    end
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (bus.state_dbg !== 3'd0 || bus.cpu_hold !== 1'b0) begin
      bad++; $display("FAIL reset.no_spurious got st=%0d hold=%b want st=0 hold=0", bus.state_dbg, bus.cpu_hold);
    end
  endtask

  task automatic test_single_word;
    int d0, s0;
    d0 = dones; s0 = strobes;
    press(0, 1, 0, 4);
    total++;
    if (bus.state_dbg !== 3'd1 || bus.cpu_hold !== 1'b1) begin
      bad++; $display("FAIL single.start got st=%0d hold=%b want st=1 hold=1", bus.state_dbg, bus.cpu_hold);
    end
    bus.SW = 8'h81;
    press(0, 0, 1, 4);
    total++;
    if (bus.state_dbg !== 3'd2) begin
      bad++; $display("FAIL single.lo got st=%0d want 2", bus.state_dbg);
    end
    bus.SW = 8'h05;
    exp_q.push_back({8'h00, 16'h8105});
    press(0, 0, 1, 4);
    total++;
    if (bus.state_dbg !== 3'd1 || bus.cpu_hold !== 1'b1) begin
      bad++; $display("FAIL single.after_write got st=%0d hold=%b want st=1 hold=1", bus.state_dbg, bus.cpu_hold);
    end
    press(0, 1, 0, 4);
    total++;
    if (dones !== d0 + 1 || strobes !== s0 + 1) begin
      bad++; $display("FAIL single.pulses got done=%0d strobes=%0d want 1 1", dones - d0, strobes - s0);
    end
    total++;
    if (bus.word_count !== 8'd1 || bus.cpu_hold !== 1'b0 || bus.state_dbg !== 3'd0 || bus.prog_data !== 16'h8105) begin
      bad++; $display("FAIL single.end got cnt=%0d hold=%b st=%0d data=%h want 1 0 0 8105",
        bus.word_count, bus.cpu_hold, bus.state_dbg, bus.prog_data);
    end
  endtask

  task automatic test_three_words;
    logic [15:0] w [3];
    int s0;
    w[0] = 16'h1100; w[1] = 16'h2200; w[2] = 16'hD000;
    s0 = strobes;
    press(0, 1, 0, 4);
    for (int i = 0; i < 3; i++) begin
      bus.SW = w[i][15:8];
      press(0, 0, 1, (i == 0) ? 20 : 4);
      bus.SW = w[i][7:0];
      exp_q.push_back({i[7:0], w[i]});
      press(0, 0, 1, (i == 0) ? 20 : 4);
    end
    press(0, 1, 0, 4);
    total++;
    if (bus.word_count !== 8'd3 || bus.full !== 1'b0 || strobes !== s0 + 3 || bus.prog_addr !== 8'd3) begin
      bad++; $display("FAIL three.end got cnt=%0d full=%b strobes=%0d addr=%0d want 3 0 3 3",
        bus.word_count, bus.full, strobes - s0, bus.prog_addr);
    end
  endtask

  task automatic test_half_word;
    int d0, s0;
    d0 = dones; s0 = strobes;
    press(0, 1, 0, 4);
    bus.SW = 8'hAA;
    press(0, 0, 1, 4);
    press(0, 1, 0, 4);
    total++;
    if (strobes !== s0 || dones !== d0 + 1 || bus.word_count !== 8'd0 || bus.state_dbg !== 3'd0) begin
      bad++; $display("FAIL half.end got strobes=%0d done=%0d cnt=%0d st=%0d want 0 1 0 0",
        strobes - s0, dones - d0, bus.word_count, bus.state_dbg);
    end
  endtask

  task automatic test_same_cycle;
    bus.SW = 8'h77;
    press(0, 1, 1, 4);
    total++;
    if (bus.state_dbg !== 3'd1 || bus.cpu_hold !== 1'b1) begin
      bad++; $display("FAIL same.start got st=%0d hold=%b want st=1 hold=1", bus.state_dbg, bus.cpu_hold);
    end
    bus.SW = 8'h12;
    press(0, 0, 1, 4);
    total++;
    if (bus.state_dbg !== 3'd2) begin
      bad++; $display("FAIL same.hi got st=%0d want 2", bus.state_dbg);
    end
    bus.SW = 8'h34;
    exp_q.push_back({8'h00, 16'h1234});
    press(0, 0, 1, 4);
    press(0, 1, 0, 4);
    total++;
    if (bus.word_count !== 8'd1) begin
      bad++; $display("FAIL same.count got=%0d want 1", bus.word_count);
    end
  endtask

  task automatic test_latency;
    int n;
    press(0, 1, 0, 4);
    bus.SW = 8'h56;
    press(0, 0, 1, 4);
    bus.SW = 8'h78;
    exp_q.push_back({8'h00, 16'h5678});
    @(posedge clk); #1;
    bus.key_enter = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.prog_we === 1'b1) break;
    end
    total++;
    if (n !== 4) begin
      bad++; $display("FAIL latency.enter_to_we got=%0d edges want 4", n);
    end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (bus.state_dbg !== 3'd1) begin
      bad++; $display("FAIL latency.held_key got st=%0d want 1", bus.state_dbg);
    end
    bus.key_enter = 1'b1;
    repeat (6) @(posedge clk);
    press(0, 1, 0, 4);
  endtask

  task automatic test_reset_mid;
    int s0;
    press(0, 1, 0, 4);
    bus.SW = 8'h9A;
    press(0, 0, 1, 4);
    total++;
    if (bus.state_dbg !== 3'd2) begin
      bad++; $display("FAIL rstmid.lo got st=%0d want 2", bus.state_dbg);
    end
    s0 = strobes;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.prog_we, bus.prog_addr, bus.prog_data, bus.cpu_hold, bus.word_count,
         bus.full, bus.done, bus.state_dbg} !== 38'd0) begin
      bad++; $display("FAIL rstmid.async got we=%b addr=%h data=%h hold=%b cnt=%h st=%0d want all 0",
        bus.prog_we, bus.prog_addr, bus.prog_data, bus.cpu_hold, bus.word_count, bus.state_dbg);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (bus.state_dbg !== 3'd0 || strobes !== s0) begin
      bad++; $display("FAIL rstmid.after got st=%0d strobes=%0d want 0 0", bus.state_dbg, strobes - s0);
    end
    press(0, 1, 0, 4);
    bus.SW = 8'h11;
    press(0, 0, 1, 4);
    bus.SW = 8'h22;
    exp_q.push_back({8'h00, 16'h1122});
    press(0, 0, 1, 4);
    press(0, 1, 0, 4);
    total++;
    if (bus.word_count !== 8'd1 || strobes !== s0 + 1) begin
      bad++; $display("FAIL rstmid.fresh got cnt=%0d strobes=%0d want 1 1", bus.word_count, strobes - s0);
    end
  endtask

  task automatic test_last_addr;
    int d0, s0;
    d0 = dones2; s0 = strobes2;
    press(1, 1, 0, 4);
    bus2.SW = 8'hAB; press(1, 0, 1, 4);
    bus2.SW = 8'h01; exp2_q.push_back({8'h00, 16'hAB01}); press(1, 0, 1, 4);
    bus2.SW = 8'hCD; press(1, 0, 1, 4);
    bus2.SW = 8'h02; exp2_q.push_back({8'h01, 16'hCD02}); press(1, 0, 1, 4);
    total++;
    if (bus2.state_dbg !== 3'd0 || bus2.full !== 1'b1 || bus2.word_count !== 8'd2 ||
        bus2.prog_addr !== 8'd1 || bus2.cpu_hold !== 1'b0) begin
      bad++; $display("FAIL last.auto_done got st=%0d full=%b cnt=%0d addr=%0d hold=%b want 0 1 2 1 0",
        bus2.state_dbg, bus2.full, bus2.word_count, bus2.prog_addr, bus2.cpu_hold);
    end
    total++;
    if (dones2 !== d0 + 1 || strobes2 !== s0 + 2) begin
      bad++; $display("FAIL last.pulses got done=%0d strobes=%0d want 1 2", dones2 - d0, strobes2 - s0);
    end
    bus2.SW = 8'hEE;
    press(1, 0, 1, 4);
    total++;
    if (bus2.state_dbg !== 3'd0 || strobes2 !== s0 + 2) begin
      bad++; $display("FAIL last.idle_enter got st=%0d strobes=%0d want 0 2", bus2.state_dbg, strobes2 - s0);
    end
  endtask

  task automatic test_fill;
    int d0, s0;
    logic [7:0] b;
    d0 = dones; s0 = strobes;
    press(0, 1, 0, 4);
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      bus.SW = b;
      press(0, 0, 1, 4);
      bus.SW = ~b;
      exp_q.push_back({b, b, ~b});
      press(0, 0, 1, 4);
      if (i == 254) begin
        total++;
        if (bus.full !== 1'b0 || bus.word_count !== 8'd255 || bus.state_dbg !== 3'd1) begin
          bad++; $display("FAIL fill.almost got full=%b cnt=%0d st=%0d want 0 255 1",
            bus.full, bus.word_count, bus.state_dbg);
        end
      end
    end
    total++;
    if (bus.full !== 1'b1 || bus.word_count !== 8'd255 || bus.prog_addr !== 8'd255 || bus.state_dbg !== 3'd0) begin
      bad++; $display("FAIL fill.end got full=%b cnt=%0d addr=%0d st=%0d want 1 255 255 0",
        bus.full, bus.word_count, bus.prog_addr, bus.state_dbg);
    end
    total++;
    if (dones !== d0 + 1 || strobes !== s0 + 256) begin
      bad++; $display("FAIL fill.pulses got done=%0d strobes=%0d want 1 256", dones - d0, strobes - s0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.SW = 8'd0; bus.key_load = 1'b1; bus.key_enter = 1'b1;
    bus2.SW = 8'd0; bus2.key_load = 1'b1; bus2.key_enter = 1'b1;
    test_reset();
    test_single_word();
    test_three_words();
    test_half_word();
    test_same_cycle();
    test_latency();
    test_reset_mid();
    test_last_addr();
    test_fill();
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() !== 0 || exp2_q.size() !== 0) begin
      bad++; $display("FAIL scoreboard.leftover got=%0d,%0d want 0,0", exp_q.size(), exp2_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
